// File: rtl/ex_mdu_pkg.sv
// EX-stage multiply/divide unit: shared op encodings,
// FSM states and default latencies.
package ex_mdu_pkg;

    localparam int unsigned MD_OP_W         = 4;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    // Ops that launch a multi-cycle computation.
    function automatic logic is_arith(
        input logic [MD_OP_W-1:0] op
    );
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(
        input logic [MD_OP_W-1:0] op
    );
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// E-stage request/response bundle between the
// execute datapath and the multiply/divide unit.
interface ex_mdu_if;
    import ex_mdu_pkg::*;

    logic [MD_OP_W-1:0] E_md_op;
    logic               E_start;
    logic [31:0]        E_rs;
    logic [31:0]        E_rt;
    logic [31:0]        E_md_result;
    logic               E_busy;
    logic               E_md_stall;

    modport master (
        output E_md_op,
        output E_start,
        output E_rs,
        output E_rt,
        input  E_md_result,
        input  E_busy,
        input  E_md_stall
    );

    modport slave (
        input  E_md_op,
        input  E_start,
        input  E_rs,
        input  E_rt,
        output E_md_result,
        output E_busy,
        output E_md_stall
    );

endinterface

// File: rtl/ex_mdu_md_arith.sv
// Combinational product / quotient / remainder from
// the latched operands; wr_o low on divide-by-zero.
module md_arith
    import ex_mdu_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    logic signed [63:0] s_a64;
    logic signed [63:0] s_b64;
    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic signed [32:0] s_a33;
    logic signed [32:0] s_b33;
    logic signed [32:0] s_quot;
    logic signed [32:0] s_rem;
    logic        [31:0] u_b;
    logic        [31:0] u_quot;
    logic        [31:0] u_rem;
    logic               b_zero;
    logic               unused_bits;

    assign b_zero = (b_i == 32'd0);

    // A zero divisor is replaced by 1 so the dividers
    // never see 0; the result is discarded anyway.
    // 33-bit signed divide keeps 0x80000000/-1 exact.
    always_comb begin
        s_a64  = {{32{a_i[31]}}, a_i};
        s_b64  = {{32{b_i[31]}}, b_i};
        s_prod = s_a64 * s_b64;
        u_prod = {32'd0, a_i} * {32'd0, b_i};
        s_a33  = {a_i[31], a_i};
        s_b33  = b_zero ? 33'sd1 : {b_i[31], b_i};
        s_quot = s_a33 / s_b33;
        s_rem  = s_a33 % s_b33;
        u_b    = b_zero ? 32'd1 : b_i;
        u_quot = a_i / u_b;
        u_rem  = a_i % u_b;
    end

    assign unused_bits = s_quot[32] ^ s_rem[32];

    // Select the HI/LO pair for the latched op.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        wr_o = 1'b0;
        unique case (op_i)
            MD_MULT: begin
                hi_o = s_prod[63:32];
                lo_o = s_prod[31:0];
                wr_o = 1'b1;
            end
            MD_MULTU: begin
                hi_o = u_prod[63:32];
                lo_o = u_prod[31:0];
                wr_o = 1'b1;
            end
            MD_DIV: begin
                hi_o = s_rem[31:0];
                lo_o = s_quot[31:0];
                wr_o = ~b_zero;
            end
            MD_DIVU: begin
                hi_o = u_rem;
                lo_o = u_quot;
                wr_o = ~b_zero;
            end
            default: begin
                hi_o = '0;
                lo_o = '0;
                wr_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO
// registers, busy counter and md-class stall.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic     clk,
    input logic     reset,
    ex_mdu_if.slave bus
);

    localparam logic [CNT_W-1:0] MULT_LD =
        CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD =
        CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE =
        CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      ar_hi;
    logic [31:0]      ar_lo;
    logic             ar_wr;
    logic [31:0]      res;

    md_arith u_arith (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_o (ar_hi),
        .lo_o (ar_lo),
        .wr_o (ar_wr)
    );

    // State, counter, operand and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Launch in IDLE, count down in BUSY, commit at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.E_start &&
                    is_arith(bus.E_md_op)) begin
                    state_d = S_BUSY;
                    op_d    = md_op_e'(bus.E_md_op);
                    a_d     = bus.E_rs;
                    b_d     = bus.E_rt;
                    cnt_d   = is_mult(bus.E_md_op) ?
                              MULT_LD : DIV_LD;
                end else if (bus.E_md_op == MD_MTHI) begin
                    hi_d = bus.E_rs;
                end else if (bus.E_md_op == MD_MTLO) begin
                    lo_d = bus.E_rs;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (ar_wr) begin
                        hi_d = ar_hi;
                        lo_d = ar_lo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // mfhi/mflo read path; zero for every other op.
    always_comb begin
        res = '0;
        if (bus.E_md_op == MD_MFHI) begin
            res = hi_q;
        end else if (bus.E_md_op == MD_MFLO) begin
            res = lo_q;
        end
    end

    assign bus.E_md_result = res;
    assign bus.E_busy      = (state_q == S_BUSY);
    assign bus.E_md_stall  = bus.E_start |
                             (state_q == S_BUSY);

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized bench for ex_mdu against a cycle-level
// model built from absolute completion cycles.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ex_mdu_if mif ();

    ex_mdu #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          cyc    = 0;
    int          m_done = -1;
    bit          chk_en = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    bit          p_wr;
    logic [31:0] s_res;
    logic        s_busy;
    logic        s_stall;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h",
                     tag, got, exp);
        end
    endtask

    task automatic ref_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] hi,
                          output logic [31:0] lo,
                          output bit wr);
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned up;
        hi = '0;
        lo = '0;
        wr = 1'b1;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) *
                     longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            4'd2: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            4'd3: begin
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    sq = longint'($signed(a)) /
                         longint'($signed(b));
                    sr = longint'($signed(a)) %
                         longint'($signed(b));
                    hi = sr[31:0];
                    lo = sq[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endtask

    task automatic model_edge();
        logic [3:0] op;
        op = mif.E_md_op;
        if (!reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_done = -1;
        end else if (cyc <= m_done) begin
            if (cyc == m_done && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (mif.E_start && op >= 4'd1 &&
                     op <= 4'd4) begin
            m_done = cyc + ((op <= 4'd2) ? MC : DC);
            ref_op(op, mif.E_rs, mif.E_rt,
                   p_hi, p_lo, p_wr);
        end else if (op == 4'd5) begin
            m_hi = mif.E_rs;
        end else if (op == 4'd6) begin
            m_lo = mif.E_rs;
        end
    endtask

    task automatic tick();
        logic        eb;
        logic [31:0] er;
        @(negedge clk);
        s_res   = mif.E_md_result;
        s_busy  = mif.E_busy;
        s_stall = mif.E_md_stall;
        if (chk_en) begin
            eb = (cyc <= m_done);
            er = '0;
            if (mif.E_md_op == 4'd7) er = m_hi;
            if (mif.E_md_op == 4'd8) er = m_lo;
            chk("busy", {31'd0, s_busy}, {31'd0, eb});
            chk("stall", {31'd0, s_stall},
                {31'd0, mif.E_start | eb});
            chk("result", s_res, er);
        end
        @(posedge clk);
        model_edge();
        cyc++;
        chk_en = 1'b1;
        #1;
    endtask

    task automatic drive(input logic [3:0] op,
                         input logic st,
                         input logic [31:0] rs,
                         input logic [31:0] rt);
        mif.E_md_op = op;
        mif.E_start = st;
        mif.E_rs    = rs;
        mif.E_rt    = rt;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            drive(4'd0, 1'b0, $urandom, $urandom);
            tick();
            if (s_busy) n++;
            else break;
        end
        if (s_busy) chk("wait_bound", 32'd1, 32'd0);
    endtask

    task automatic read(input string tag,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
        drive(4'd7, 1'b0, 32'd0, 32'd0);
        tick();
        chk({tag, "_hi"}, s_res, ehi);
        drive(4'd8, 1'b0, 32'd0, 32'd0);
        tick();
        chk({tag, "_lo"}, s_res, elo);
        drive(4'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic run(input string tag,
                       input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int len);
        int n;
        drive(op, 1'b1, a, b);
        tick();
        wait_idle(n);
        chk({tag, "_len"}, n, len);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] t [5];
        t[0] = 32'h0000_0000;
        t[1] = 32'h0000_0001;
        t[2] = 32'hFFFF_FFFF;
        t[3] = 32'h8000_0000;
        t[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 2) == 0)
            return t[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int          n;
        int          c;
        logic [3:0]  op;
        drive(4'd0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        drive(4'd1, 1'b1, 32'hFFFF_FFFF, 32'd2);
        tick();
        reset = 1'b1;
        drive(4'd0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("rst_start_busy", {31'd0, s_busy}, 32'd0);
        read("rst", 32'd0, 32'd0);

        run("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, MC);
        read("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, MC);
        read("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        run("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC);
        read("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", 4'd4, 32'd7, 32'd2, DC);
        read("divu", 32'd1, 32'd3);

        drive(4'd5, 1'b0, 32'h1234, 32'd0);
        tick();
        drive(4'd6, 1'b0, 32'h5678, 32'd0);
        tick();
        run("div0", 4'd3, 32'h55, 32'd0, DC);
        read("div0", 32'h1234, 32'h5678);
        run("ovf", 4'd3, 32'h8000_0000,
            32'hFFFF_FFFF, DC);
        read("ovf", 32'd0, 32'h8000_0000);

        drive(4'd1, 1'b1, 32'd3, 32'd4);
        tick();
        drive(4'd0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", {31'd0, s_busy}, 32'd0);
        repeat (8) tick();
        read("abort", 32'd0, 32'd0);

        drive(4'd1, 1'b1, 32'h0001_0000, 32'h0001_0000);
        tick();
        drive(4'd3, 1'b1, 32'd100, 32'd7);
        tick();
        drive(4'd5, 1'b0, 32'hAAAA, 32'd0);
        tick();
        wait_idle(n);
        chk("ign_len", n, MC - 2);
        read("ign", 32'd1, 32'd0);

        drive(4'd6, 1'b0, 32'hBEEF, 32'd0);
        tick();
        drive(4'd8, 1'b0, 32'd0, 32'd0);
        tick();
        chk("mflo_beef", s_res, 32'hBEEF);

        drive(4'd3, 1'b1, 32'd100, 32'd7);
        tick();
        c = s_stall ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            drive(4'd0, 1'b0, 32'd0, 32'd0);
            tick();
            if (s_stall) c++;
            else break;
        end
        chk("stall_len", c, DC + 1);
        read("stall", 32'd2, 32'd14);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                op = 4'($urandom_range(1, 4));
                drive(op, 1'b1, pick(), pick());
            end else begin
                op = 4'($urandom_range(0, 15));
                drive(op, 1'($urandom_range(0, 1)),
                      pick(), pick());
            end
            reset = ($urandom_range(0, 99) < 2) ?
                    1'b0 : 1'b1;
            tick();
        end
        reset = 1'b1;
        wait_idle(n);
        read("final", m_hi, m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
